mvm_host_scheduler: RTL and testbench
=====================================

# mvm_host_scheduler

Sequencer between the 8-bit host byte port and the sparse MVM accelerator. It parses host command bytes and loads up to 16 CSR entries into the accelerator through its start / FETCH_ready / sending_CPU / done_list handshake. It issues the 4-bit spike train and collects the four toggle-signalled results. It then streams those results back to the host over a valid/ready port, guarding every accelerator wait with a timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles waited on any accelerator event before abort (8-bit counter, 1..255).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- host_data  in  8  command/payload byte from host.
- host_valid  in  1  host_data valid.
- host_ready  out  1  scheduler accepts byte; transfer when host_valid && host_ready.
- res_data  out  8  result byte to host.
- res_valid  out  1  res_data valid.
- res_ready  in  1  host accepts result; transfer when res_valid && res_ready.
- busy  out  1  high in every state except IDLE.
- err  out  2  0 none, 1 bad command, 2 run without matrix, 3 timeout.
- acc_start  out  1  one-cycle pulse opening a matrix load.
- acc_row  out  2  CSR row of current entry.
- acc_col  out  2  CSR column of current entry.
- acc_value  out  8  entry value, or {4'b0, spike} during run.
- acc_sending  out  1  one-cycle pulse: acc_row/col/value valid.
- acc_done_list  out  1  one-cycle pulse: last entry sent.
- acc_fetch_ready  in  1  accelerator can take the next word.
- acc_result  in  8  accelerator output value.
- acc_result_tgl  in  1  toggles once per presented result.

## Operation
Commands, taken as the first byte accepted in IDLE:
- 8'h1N = LOAD with N+1 entries (1..16). Followed by N+1 pairs: byte A = {row[1:0], col[1:0], 4'b0}, byte B = value.
- 8'h2S = RUN with spike train S[3:0].
- Any other byte sets err=1, stays in IDLE, and does not touch the accelerator.

States:
- IDLE: host_ready=1. Accepting a command byte clears err.
  - LOAD -> L_START.
  - RUN with loaded=1 -> R_ISSUE.
  - RUN with loaded=0 -> err=2, stay in IDLE.
- L_START: acc_start=1 for one cycle; clear entry counter; -> L_WAIT.
- L_WAIT: wait for acc_fetch_ready=1 -> L_A, or -> L_DONE if all entries have been sent.
- L_A: host_ready=1; accept byte A; latch row/col -> L_B.
- L_B: host_ready=1; accept byte B; latch value -> L_ISSUE.
- L_ISSUE: acc_sending=1 for one cycle; increment counter -> L_GAP.
- L_GAP: one-cycle gap so fetch_ready can drop -> L_WAIT.
- L_DONE: acc_done_list=1 for one cycle; loaded=1 -> IDLE.
- R_ISSUE: wait for acc_fetch_ready=1, then drive acc_sending=1 for one cycle with acc_value={4'b0,S} -> R_COLLECT.
- R_COLLECT: capture results into buffer[k]; after k=3 -> R_STREAM.
- R_STREAM: present buffer[0..3] in order; after the 4th transfer -> IDLE.

Rules:
- Result edge detection: tgl_q <= acc_result_tgl every cycle in all states. A capture happens when acc_result_tgl != tgl_q while in R_COLLECT. Toggles outside R_COLLECT are discarded.
- Timeout: an 8-bit counter clears on entry to L_WAIT, R_ISSUE and R_COLLECT, and on each captured result. It increments while waiting. When it reaches TIMEOUT_CYCLES: err=3, loaded=0, -> IDLE, and the partial result buffer is discarded. Host-side waits (L_A, L_B, R_STREAM) have no timeout.
- err is sticky until the next accepted command byte.
- loaded stays set across runs. A new LOAD clears it at L_START and sets it again at L_DONE.
- All accelerator outputs are registered. acc_row/col/value hold their last value between pulses.

## Timing
- Reset values:
  - host_ready=0, res_valid=0, res_data=0, busy=0, err=0.
  - acc_start=0, acc_sending=0, acc_done_list=0, acc_row=0, acc_col=0, acc_value=0.
  - Internal: loaded=0, tgl_q=0, state IDLE.
  - host_ready rises on the first clock after reset deasserts.
- Assertion of rst_n mid-operation forces reset values immediately and drops any partially loaded matrix.
- acc_start is asserted the cycle after LOAD is accepted.
- acc_sending is asserted 1 cycle after byte B is accepted, provided fetch_ready was already high at L_WAIT.
- Per entry: minimum 5 cycles (L_WAIT, L_A, L_B, L_ISSUE, L_GAP) with host_valid held high.
- Result capture: one capture per clock at most. Two toggles on consecutive cycles give two captures.
- res_valid rises the cycle after the 4th capture. res_data is stable while res_valid=1 && res_ready=0.

## Test plan
- LOAD 8'h10 with one entry (A=8'h40, B=8'h07): one acc_start pulse; one acc_sending pulse with row=1, col=0, value=7; one acc_done_list pulse; back in IDLE with loaded=1, err=0.
- LOAD 8'h1F with 16 entries, fetch_ready held high: exactly 16 acc_sending pulses, each separated by at least one L_GAP cycle, then acc_done_list.
- RUN 8'h25 after a load; model toggles acc_result_tgl with results 8'h03, 8'h00, 8'h11, 8'hFF: acc_value=8'h05 when acc_sending pulses; host then receives 03, 00, 11, FF in order, including while res_ready is stalled 3 cycles.
- RUN 8'h2A straight after reset -> err=2, no accelerator pulses. A following byte 8'h77 -> err=1.
- RUN with the model producing only 2 toggles, TIMEOUT_CYCLES=8: err=3 at 8 cycles after the last capture; loaded=0; res_valid never rises.
- Assert rst_n low during L_B: all outputs return to reset values in the same cycle; a subsequent RUN gives err=2.

Source files
------------

// File: rtl/mvm_host_scheduler.sv
// mvm_host_scheduler
// Sequencer between an 8-bit host byte port and the sparse MVM accelerator.
// It parses host commands, loads up to 16 CSR entries into the accelerator,
// issues a 4-bit spike train and collects four toggle-signalled results.
// It then streams those results back to the host. Every accelerator wait
// is guarded by a timeout.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   host_data/valid     command and payload bytes from the host
//   host_ready          byte accepted when host_valid && host_ready
//   res_data/valid      result bytes to the host
//   res_ready           result accepted when res_valid && res_ready
//   busy                high whenever the sequencer is not idle
//   err                 0 none, 1 bad command, 2 run without matrix, 3 timeout
//   acc_start           one-cycle pulse opening a matrix load
//   acc_row/col/value   current entry (or {4'b0, spike} during a run)
//   acc_sending         one-cycle pulse: acc_row/col/value are valid
//   acc_done_list       one-cycle pulse: the last entry has been sent
//   acc_fetch_ready     accelerator can take the next word
//   acc_result          accelerator result value
//   acc_result_tgl      toggles once per presented result

module mvm_host_scheduler #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] host_data,
   input  logic       host_valid,
   output logic       host_ready,
   output logic [7:0] res_data,
   output logic       res_valid,
   input  logic       res_ready,
   output logic       busy,
   output logic [1:0] err,
   output logic       acc_start,
   output logic [1:0] acc_row,
   output logic [1:0] acc_col,
   output logic [7:0] acc_value,
   output logic       acc_sending,
   output logic       acc_done_list,
   input  logic       acc_fetch_ready,
   input  logic [7:0] acc_result,
   input  logic       acc_result_tgl
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_L_START   = 4'd1;
   localparam logic [3:0] S_L_WAIT    = 4'd2;
   localparam logic [3:0] S_L_A       = 4'd3;
   localparam logic [3:0] S_L_B       = 4'd4;
   localparam logic [3:0] S_L_ISSUE   = 4'd5;
   localparam logic [3:0] S_L_GAP     = 4'd6;
   localparam logic [3:0] S_L_DONE    = 4'd7;
   localparam logic [3:0] S_R_ISSUE   = 4'd8;
   localparam logic [3:0] S_R_COLLECT = 4'd9;
   localparam logic [3:0] S_R_STREAM  = 4'd10;

   // The abort fires on the cycle the counter would reach TIMEOUT_CYCLES.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [3:0] state;
   logic [3:0] state_nx;
   logic       host_xfer;
   logic       res_xfer;
   logic       capture;
   logic       tmo_hit;
   logic       tmo_abort;
   logic       waiting;
   logic       loaded;
   logic       tgl_q;
   logic [7:0] tmo_cnt;
   logic [4:0] ent_cnt;
   logic [4:0] ent_total;
   logic [1:0] row_q;
   logic [1:0] col_q;
   logic [3:0] spike;
   logic [1:0] res_idx;
   logic [1:0] res_idx_nx;
   logic [7:0] res_buf [4];

   // Next-state decode. Timeout aborts are flagged here so the register
   // block can set err and drop the loaded matrix on the same edge.
   always_comb begin
      state_nx   = state;
      tmo_abort  = 1'b0;
      host_xfer  = host_valid && host_ready;
      res_xfer   = res_valid && res_ready;
      capture    = (state == S_R_COLLECT) && (acc_result_tgl != tgl_q);
      tmo_hit    = (tmo_cnt == TMO_LAST);
      res_idx_nx = res_idx + 2'd1;
      waiting    = (state == S_L_WAIT) || (state == S_R_ISSUE) ||
                   (state == S_R_COLLECT);
      case (state)
         S_IDLE: begin
            if (host_xfer) begin
               if (host_data[7:4] == 4'h1) begin
                  state_nx = S_L_START;
               end else if (host_data[7:4] == 4'h2 && loaded) begin
                  state_nx = S_R_ISSUE;
               end
            end
         end
         S_L_START: state_nx = S_L_WAIT;
         S_L_WAIT: begin
            if (ent_cnt == ent_total) begin
               state_nx = S_L_DONE;
            end else if (acc_fetch_ready) begin
               state_nx = S_L_A;
            end else if (tmo_hit) begin
               tmo_abort = 1'b1;
               state_nx  = S_IDLE;
            end
         end
         S_L_A: if (host_xfer) state_nx = S_L_B;
         S_L_B: if (host_xfer) state_nx = S_L_ISSUE;
         S_L_ISSUE: state_nx = S_L_GAP;
         S_L_GAP: state_nx = S_L_WAIT;
         S_L_DONE: state_nx = S_IDLE;
         S_R_ISSUE: begin
            if (acc_fetch_ready) begin
               state_nx = S_R_COLLECT;
            end else if (tmo_hit) begin
               tmo_abort = 1'b1;
               state_nx  = S_IDLE;
            end
         end
         S_R_COLLECT: begin
            if (capture) begin
               if (res_idx == 2'd3) state_nx = S_R_STREAM;
            end else if (tmo_hit) begin
               tmo_abort = 1'b1;
               state_nx  = S_IDLE;
            end
         end
         S_R_STREAM: if (res_xfer && res_idx == 2'd3) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // All outputs are registered from the next state so that handshake
   // strobes line up with the state they belong to. Entry fields are only
   // pushed to acc_row/col/value together with an acc_sending pulse, so they
   // hold steady between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         host_ready    <= 1'b0;
         res_data      <= 8'h00;
         res_valid     <= 1'b0;
         busy          <= 1'b0;
         err           <= 2'd0;
         acc_start     <= 1'b0;
         acc_row       <= 2'd0;
         acc_col       <= 2'd0;
         acc_value     <= 8'h00;
         acc_sending   <= 1'b0;
         acc_done_list <= 1'b0;
         loaded        <= 1'b0;
         tgl_q         <= 1'b0;
         tmo_cnt       <= 8'd0;
         ent_cnt       <= 5'd0;
         ent_total     <= 5'd0;
         row_q         <= 2'd0;
         col_q         <= 2'd0;
         spike         <= 4'd0;
         res_idx       <= 2'd0;
         for (int i = 0; i < 4; i++) res_buf[i] <= 8'h00;
      end else begin
         state         <= state_nx;
         tgl_q         <= acc_result_tgl;
         host_ready    <= (state_nx == S_IDLE) || (state_nx == S_L_A) ||
                          (state_nx == S_L_B);
         busy          <= (state_nx != S_IDLE);
         acc_start     <= (state_nx == S_L_START);
         acc_done_list <= (state_nx == S_L_DONE);
         acc_sending   <= ((state == S_L_B) && (state_nx == S_L_ISSUE)) ||
                          ((state == S_R_ISSUE) && (state_nx == S_R_COLLECT));

         // Timeout counter restarts on every state change and on every
         // captured result, and only advances in accelerator waits.
         if ((state_nx != state) || capture) begin
            tmo_cnt <= 8'd0;
         end else if (waiting) begin
            tmo_cnt <= tmo_cnt + 8'd1;
         end

         case (state)
            S_IDLE: begin
               if (host_xfer) begin
                  err <= 2'd0;
                  if (host_data[7:4] == 4'h1) begin
                     ent_total <= 5'(host_data[3:0]) + 5'd1;
                  end else if (host_data[7:4] == 4'h2) begin
                     spike   <= host_data[3:0];
                     res_idx <= 2'd0;
                     if (!loaded) err <= 2'd2;
                  end else begin
                     err <= 2'd1;
                  end
               end
            end
            S_L_START: begin
               loaded  <= 1'b0;
               ent_cnt <= 5'd0;
            end
            S_L_A: begin
               if (host_xfer) begin
                  row_q <= host_data[7:6];
                  col_q <= host_data[5:4];
               end
            end
            S_L_B: begin
               if (host_xfer) begin
                  acc_row   <= row_q;
                  acc_col   <= col_q;
                  acc_value <= host_data;
               end
            end
            S_L_ISSUE: ent_cnt <= ent_cnt + 5'd1;
            S_L_DONE: loaded <= 1'b1;
            S_R_ISSUE: begin
               if (acc_fetch_ready) begin
                  acc_value <= {4'b0000, spike};
                  res_idx   <= 2'd0;
               end
            end
            S_R_COLLECT: begin
               if (capture) begin
                  res_buf[res_idx] <= acc_result;
                  res_idx          <= res_idx_nx;
                  if (res_idx == 2'd3) begin
                     res_valid <= 1'b1;
                     res_data  <= res_buf[0];
                  end
               end
            end
            S_R_STREAM: begin
               if (res_xfer) begin
                  res_idx <= res_idx_nx;
                  if (res_idx == 2'd3) begin
                     res_valid <= 1'b0;
                  end else begin
                     res_data <= res_buf[res_idx_nx];
                  end
               end
            end
            default: ;
         endcase

         // A timed-out wait invalidates the matrix and any partial results.
         if (tmo_abort) begin
            err     <= 2'd3;
            loaded  <= 1'b0;
            res_idx <= 2'd0;
         end
      end
   end

endmodule

// File: tb/tb_mvm_host_scheduler.sv
// tb_mvm_host_scheduler
// Self-checking bench for mvm_host_scheduler. A behavioural model tracks
// whether a matrix is loaded, which entries were sent and which results are
// owed to the host; a monitor logs accelerator strobes on the falling edge.

module tb_mvm_host_scheduler;

   logic       clk;
   logic       rst_n;
   logic [7:0] host_data;
   logic       host_valid;
   logic       host_ready;
   logic [7:0] res_data;
   logic       res_valid;
   logic       res_ready;
   logic       busy;
   logic [1:0] err;
   logic       acc_start;
   logic [1:0] acc_row;
   logic [1:0] acc_col;
   logic [7:0] acc_value;
   logic       acc_sending;
   logic       acc_done_list;
   logic       acc_fetch_ready;
   logic [7:0] acc_result;
   logic       acc_result_tgl;

   mvm_host_scheduler #(.TIMEOUT_CYCLES(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .host_data       (host_data),
      .host_valid      (host_valid),
      .host_ready      (host_ready),
      .res_data        (res_data),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .busy            (busy),
      .err             (err),
      .acc_start       (acc_start),
      .acc_row         (acc_row),
      .acc_col         (acc_col),
      .acc_value       (acc_value),
      .acc_sending     (acc_sending),
      .acc_done_list   (acc_done_list),
      .acc_fetch_ready (acc_fetch_ready),
      .acc_result      (acc_result),
      .acc_result_tgl  (acc_result_tgl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit         model_loaded = 0;
   logic [1:0] ent_row [16];
   logic [1:0] ent_col [16];
   logic [7:0] ent_val [16];
   logic [7:0] res_in  [4];

   // Strobe monitor, sampled on the falling edge away from the active edge
   int          cyc = 0;
   int          start_cnt = 0;
   int          send_cnt = 0;
   int          done_cnt = 0;
   int          resv_cnt = 0;
   int          last_send_cyc = 0;
   int          min_gap = 1000;
   logic [11:0] send_log [$];

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (acc_start) begin
            start_cnt++;
            min_gap = 1000;
         end
         if (acc_sending) begin
            if ((cyc - last_send_cyc) < min_gap) min_gap = cyc - last_send_cyc;
            last_send_cyc = cyc;
            send_cnt++;
            send_log.push_back({acc_row, acc_col, acc_value});
         end
         if (acc_done_list) done_cnt++;
         if (res_valid) resv_cnt++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // Offer one host byte and return on the falling edge after it transfers.
   task automatic applyStimulus(input logic [7:0] b);
      int n;
      n = 0;
      host_data  = b;
      host_valid = 1'b1;
      while (!host_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!host_ready) begin
         checkOutput("host_ready_wait", host_ready, 1);
         host_valid = 1'b0;
         return;
      end
      @(negedge clk);
      host_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("idle_wait", busy, 0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_host_ready"}, host_ready, 0);
      checkOutput({tag, "_res"}, {res_valid, res_data}, 0);
      checkOutput({tag, "_busy_err"}, {busy, err}, 0);
      checkOutput({tag, "_strobes"}, {acc_start, acc_sending, acc_done_list}, 0);
      checkOutput({tag, "_entry"}, {acc_row, acc_col, acc_value}, 0);
   endtask

   // Load n entries from ent_* and check strobes and logged entries.
   task automatic loadMatrix(input int n);
      int start0, send0, done0, log0;
      start0 = start_cnt;
      send0  = send_cnt;
      done0  = done_cnt;
      log0   = send_log.size();
      applyStimulus(8'h10 | 8'(n - 1));
      checkOutput("acc_start_latency", acc_start, 1);
      checkOutput("err_cleared", err, 0);
      for (int i = 0; i < n; i++) begin
         applyStimulus({ent_row[i], ent_col[i], 4'h0});
         applyStimulus(ent_val[i]);
         if (i == 0) checkOutput("sending_latency", acc_sending, 1);
      end
      waitIdle();
      @(negedge clk);
      checkOutput("load_start_pulses", start_cnt - start0, 1);
      checkOutput("load_send_pulses", send_cnt - send0, n);
      checkOutput("load_done_pulses", done_cnt - done0, 1);
      checkOutput("load_err", err, 0);
      if (n > 1) checkOutput("load_gap_ok", (min_gap >= 2), 1);
      for (int i = 0; i < n; i++) begin
         if (log0 + i < send_log.size())
            checkOutput("load_entry", send_log[log0 + i],
                        {ent_row[i], ent_col[i], ent_val[i]});
         else
            checkOutput("load_entry_missing", send_log.size(), log0 + i + 1);
      end
      model_loaded = 1;
   endtask

   // Issue a RUN; the accelerator model presents ntgl results from res_in.
   task automatic runMatrix(input logic [3:0] s, input int ntgl);
      int n, start0, send0, done0, resv0, gap, stall;
      start0 = start_cnt;
      send0  = send_cnt;
      done0  = done_cnt;
      resv0  = resv_cnt;
      applyStimulus(8'h20 | 8'(s));
      if (!model_loaded) begin
         checkOutput("run_unloaded_err", err, 2);
         repeat (3) @(negedge clk);
         checkOutput("run_unloaded_busy", busy, 0);
         checkOutput("run_unloaded_pulses",
                     (start_cnt - start0) + (send_cnt - send0) + (done_cnt - done0), 0);
         return;
      end
      n = 0;
      while (!acc_sending && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("run_sending", acc_sending, 1);
      checkOutput("run_spike_value", acc_value, {4'h0, s});
      for (int i = 0; i < ntgl; i++) begin
         gap = (i == 1) ? 0 : int'($urandom_range(0, 2));
         repeat (gap) @(negedge clk);
         acc_result     = res_in[i];
         acc_result_tgl = ~acc_result_tgl;
         @(negedge clk);
      end
      if (ntgl < 4) begin
         for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checkOutput("timeout_early", err, 0);
         end
         @(negedge clk);
         checkOutput("timeout_err", err, 3);
         checkOutput("timeout_idle", busy, 0);
         checkOutput("timeout_no_results", resv_cnt - resv0, 0);
         model_loaded = 0;
         return;
      end
      checkOutput("res_valid_rise", res_valid, 1);
      for (int i = 0; i < 4; i++) begin
         stall = (i == 1) ? 3 : int'($urandom_range(0, 1));
         res_ready = 1'b0;
         for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            checkOutput("stall_hold", {res_valid, res_data}, {1'b1, res_in[i]});
         end
         res_ready = 1'b1;
         checkOutput("result_byte", {res_valid, res_data}, {1'b1, res_in[i]});
         @(negedge clk);
      end
      res_ready = 1'b0;
      checkOutput("stream_end", {res_valid, busy}, 0);
      checkOutput("run_start_pulses", start_cnt - start0, 0);
      checkOutput("run_send_pulses", send_cnt - send0, 1);
   endtask

   task automatic randomEntries(input int n);
      for (int i = 0; i < n; i++) begin
         ent_row[i] = 2'($urandom_range(0, 3));
         ent_col[i] = 2'($urandom_range(0, 3));
         ent_val[i] = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic randomResults();
      for (int i = 0; i < 4; i++) res_in[i] = 8'($urandom_range(0, 255));
   endtask

   initial begin
      rst_n           = 1'b0;
      host_data       = 8'h00;
      host_valid      = 1'b0;
      res_ready       = 1'b0;
      acc_fetch_ready = 1'b1;
      acc_result      = 8'h00;
      acc_result_tgl  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkResetValues("reset");
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("host_ready_after_reset", host_ready, 1);

      // RUN with no matrix, then an unknown command byte
      runMatrix(4'hA, 4);
      applyStimulus(8'h77);
      checkOutput("bad_cmd_err", err, 1);
      checkOutput("bad_cmd_idle", {busy, host_ready}, 2'b01);

      // Single fixed entry, then the fixed result sequence
      ent_row[0] = 2'd1;
      ent_col[0] = 2'd0;
      ent_val[0] = 8'h07;
      loadMatrix(1);
      res_in[0] = 8'h03;
      res_in[1] = 8'h00;
      res_in[2] = 8'h11;
      res_in[3] = 8'hFF;
      runMatrix(4'h5, 4);

      // Full 16-entry matrix, two runs on it; a stray toggle in IDLE is ignored
      randomEntries(16);
      loadMatrix(16);
      randomResults();
      runMatrix(4'($urandom_range(0, 15)), 4);
      acc_result_tgl = ~acc_result_tgl;
      @(negedge clk);
      @(negedge clk);
      randomResults();
      runMatrix(4'($urandom_range(0, 15)), 4);

      // Random-size load, then a run that produces only two results
      randomEntries(16);
      loadMatrix(int'($urandom_range(2, 8)));
      randomResults();
      runMatrix(4'($urandom_range(0, 15)), 2);
      runMatrix(4'h3, 4);

      // Load stalls with fetch_ready low until the timeout fires
      acc_fetch_ready = 1'b0;
      applyStimulus(8'h12);
      waitIdle();
      checkOutput("load_timeout_err", err, 3);
      acc_fetch_ready = 1'b1;
      model_loaded = 0;
      runMatrix(4'h1, 4);

      // Reset asserted while waiting for byte B
      randomEntries(2);
      loadMatrix(2);
      applyStimulus(8'h11);
      applyStimulus({ent_row[0], ent_col[0], 4'h0});
      host_data  = ent_val[0];
      host_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checkResetValues("midreset");
      host_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_loaded = 0;
      @(negedge clk);
      runMatrix(4'h6, 4);

      $display("[TB] stimulus complete");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
